fp32_addtree5to1_feeder: RTL and testbench

Upstream stage of the 8-channel FP32 5-to-1 adder tree. It accepts a valid/ready stream of FP32 operands and scatters them into the tree's nibble-sliced 8x128-bit source-register format. Each full or terminated batch of 32 operands is issued with a one-cycle instruction-valid pulse. Output ports connect directly to the adder tree's cru/dvr_s0..s7 inputs.

---
 rtl/fp32_addtree5to1_feeder_pkg.sv | 18 +
 rtl/fp32_addtree5to1_feeder_nibble_scatter.sv | 25 ++
 rtl/fp32_addtree5to1_feeder.sv | 84 ++++++++
 tb/tb_fp32_addtree5to1_feeder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fp32_addtree5to1_feeder_pkg.sv
// Shared constants and state encoding for the FP32 5-to-1 adder-tree feeder.
package fp32_addtree5to1_feeder_pkg;

  localparam int FP32_WIDTH     = 32;
  localparam int ADDTREE_NUM_CH = 8;
  localparam int ADDTREE_SLOTS  = 4;
  localparam int NIBBLE_W       = 4;
  localparam int BATCH          = ADDTREE_NUM_CH * ADDTREE_SLOTS;
  localparam int IDX_W          = $clog2(BATCH);
  localparam int REG_W          = BATCH * NIBBLE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH - 1);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/fp32_addtree5to1_feeder_nibble_scatter.sv
// Spreads one FP32 operand across the eight source registers: nibble j goes to
// register j at slot position idx.
module fp32_nibble_scatter
  import fp32_addtree5to1_feeder_pkg::*;
(
  input  logic [IDX_W-1:0]                         idx,
  input  logic [FP32_WIDTH-1:0]                    value,
  output logic [ADDTREE_NUM_CH-1:0][REG_W-1:0]     wr_mask,
  output logic [ADDTREE_NUM_CH-1:0][REG_W-1:0]     wr_data
);

  logic [IDX_W+1:0] base;

  assign base = {idx, 2'b00};

  always_comb begin
    wr_mask = '0;
    wr_data = '0;
    for (int j = 0; j < ADDTREE_NUM_CH; j++) begin
      wr_mask[j][base +: NIBBLE_W] = '1;
      wr_data[j][base +: NIBBLE_W] = value[j*NIBBLE_W +: NIBBLE_W];
    end
  end

endmodule

// File: rtl/fp32_addtree5to1_feeder.sv
// Collects a stream of FP32 operands into the adder tree's nibble-sliced
// source registers and issues each batch with a one-cycle instruction pulse.
module fp32_addtree5to1_feeder
  import fp32_addtree5to1_feeder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FP32_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  flush,
  input  logic                  issue_en,
  output logic                  cru_fp32addtree5to1,
  output logic [REG_W-1:0]      dvr_fp32addtree5to1_s0,
  output logic [REG_W-1:0]      dvr_fp32addtree5to1_s1,
  output logic [REG_W-1:0]      dvr_fp32addtree5to1_s2,
  output logic [REG_W-1:0]      dvr_fp32addtree5to1_s3,
  output logic [REG_W-1:0]      dvr_fp32addtree5to1_s4,
  output logic [REG_W-1:0]      dvr_fp32addtree5to1_s5,
  output logic [REG_W-1:0]      dvr_fp32addtree5to1_s6,
  output logic [REG_W-1:0]      dvr_fp32addtree5to1_s7,
  output logic                  busy,
  output logic [CNT_W-1:0]      batch_cnt
);

  state_t                                  state;
  logic [IDX_W-1:0]                        idx;
  logic [ADDTREE_NUM_CH-1:0][REG_W-1:0]    dvr;
  logic [ADDTREE_NUM_CH-1:0][REG_W-1:0]    wr_mask;
  logic [ADDTREE_NUM_CH-1:0][REG_W-1:0]    wr_data;
  logic                                    accept;
  logic                                    fire;

  assign in_ready            = (state == ST_FILL);
  assign busy                = (state == ST_ISSUE);
  assign fire                = busy & issue_en;
  assign cru_fp32addtree5to1 = fire;
  assign accept              = in_valid & in_ready;

  fp32_nibble_scatter u_scatter (
    .idx     (idx),
    .value   (in_data),
    .wr_mask (wr_mask),
    .wr_data (wr_data)
  );

  // An issue takes priority over flush: the tree samples dvr on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      idx       <= '0;
      dvr       <= '0;
      batch_cnt <= '0;
    end else if (fire) begin
      state     <= ST_FILL;
      idx       <= '0;
      dvr       <= '0;
      batch_cnt <= batch_cnt + 1'b1;
    end else if (flush) begin
      state <= ST_FILL;
      idx   <= '0;
      dvr   <= '0;
    end else if (accept) begin
      dvr <= (dvr & ~wr_mask) | wr_data;
      if (idx == LAST_IDX || in_last)
        state <= ST_ISSUE;
      if (idx != LAST_IDX)
        idx <= idx + 1'b1;
    end
  end

  assign dvr_fp32addtree5to1_s0 = dvr[0];
  assign dvr_fp32addtree5to1_s1 = dvr[1];
  assign dvr_fp32addtree5to1_s2 = dvr[2];
  assign dvr_fp32addtree5to1_s3 = dvr[3];
  assign dvr_fp32addtree5to1_s4 = dvr[4];
  assign dvr_fp32addtree5to1_s5 = dvr[5];
  assign dvr_fp32addtree5to1_s6 = dvr[6];
  assign dvr_fp32addtree5to1_s7 = dvr[7];

endmodule

// File: tb/tb_fp32_addtree5to1_feeder.sv
// Self-checking bench for the adder-tree feeder: table-driven batches with a
// scoreboard checked on every instruction pulse, plus hold/flush/reset sequences.
module tb_fp32_addtree5to1_feeder;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_data;
  logic                in_last;
  logic                flush;
  logic                issue_en;
  logic                cru;
  wire  [7:0][127:0]   s_all;
  logic                busy;
  logic [15:0]         batch_cnt;

  int compared;
  int mismatched;
  int pulses;
  int exp_pulses;
  logic [15:0] exp_cnt;

  typedef logic [7:0][127:0] regs_t;
  regs_t sb[$];
  regs_t mon_exp;

  typedef struct {
    string       name;
    int          n;
    bit          pattern;
    logic [31:0] val;
    bit          last;
    regs_t       exp;
  } vec_t;

  vec_t vecs[4];

  fp32_addtree5to1_feeder dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .in_data                (in_data),
    .in_last                (in_last),
    .flush                  (flush),
    .issue_en               (issue_en),
    .cru_fp32addtree5to1    (cru),
    .dvr_fp32addtree5to1_s0 (s_all[0]),
    .dvr_fp32addtree5to1_s1 (s_all[1]),
    .dvr_fp32addtree5to1_s2 (s_all[2]),
    .dvr_fp32addtree5to1_s3 (s_all[3]),
    .dvr_fp32addtree5to1_s4 (s_all[4]),
    .dvr_fp32addtree5to1_s5 (s_all[5]),
    .dvr_fp32addtree5to1_s6 (s_all[6]),
    .dvr_fp32addtree5to1_s7 (s_all[7]),
    .busy                   (busy),
    .batch_cnt              (batch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every pulse must match the oldest outstanding batch.
  always @(negedge clk) begin
    if (cru === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_cru: got pulse expected none at %0t", $time);
      end else begin
        mon_exp = sb.pop_front();
        for (int j = 0; j < 8; j++)
          check($sformatf("sb_s%0d", j), s_all[j], mon_exp[j]);
      end
    end
  end

  function automatic regs_t spread(input logic [31:0] v, input int n);
    regs_t r;
    r = '0;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < n; k++)
        r[j][4*k +: 4] = v[4*j +: 4];
    return r;
  endfunction

  task automatic send_op(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called at the cycle where the pulse should be visible.
  task automatic finish_issue(input string name);
    check({name, "_cru"}, 128'(cru), 128'd1);
    check({name, "_busy_rdy"}, {126'd0, busy, in_ready}, 128'b10);
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_cnt++;
    exp_pulses++;
    check({name, "_cnt"}, 128'(batch_cnt), 128'(exp_cnt));
    check({name, "_clear"}, 128'(s_all != '0), 128'd0);
    check({name, "_pulses"}, 128'(pulses), 128'(exp_pulses));
    check({name, "_ready"}, 128'(in_ready), 128'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input bit flush_on_issue);
    logic [31:0] d;
    sb.push_back(v.exp);
    issue_en = 1'b1;
    for (int n = 0; n < v.n; n++) begin
      d = v.pattern ? 32'h1111_1111 * 32'(n % 8 + 1) : v.val;
      send_op(d, v.last && (n == v.n - 1));
    end
    flush = flush_on_issue;
    finish_issue(v.name);
  endtask

  initial begin
    regs_t hold_exp;
    compared = 0; mismatched = 0; pulses = 0; exp_pulses = 0; exp_cnt = '0;
    in_valid = 0; in_data = '0; in_last = 0; flush = 0; issue_en = 0;

    vecs[0] = '{"ones32", 32, 1'b0, 32'h3F80_0000, 1'b0,
                {{32{4'h3}}, {32{4'hF}}, {32{4'h8}}, 128'd0, 128'd0, 128'd0, 128'd0, 128'd0}};
    vecs[1] = '{"two5last", 5, 1'b0, 32'h4000_0000, 1'b1,
                {128'h0000_0000_0000_0000_0000_0000_0004_4444, 896'd0}};
    vecs[2] = '{"pattern", 32, 1'b1, 32'h0, 1'b1, {8{{4{32'h8765_4321}}}}};
    vecs[3] = '{"dead12", 12, 1'b0, 32'hDEAD_BEEF, 1'b1, spread(32'hDEAD_BEEF, 12)};

    rst_n = 1'b0;
    #12;
    check("rst_s", 128'(s_all != '0), 128'd0);
    check("rst_flags", {125'd0, cru, busy, in_ready}, 128'b001);
    check("rst_cnt", 128'(batch_cnt), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      applyStimulus(vecs[i], 1'b0);

    // Full batch held off by the sequencer while upstream keeps offering data.
    hold_exp = spread(32'hA5A5_5A5A, 32);
    sb.push_back(hold_exp);
    issue_en = 1'b0;
    for (int n = 0; n < 32; n++) send_op(32'hA5A5_5A5A, 1'b0);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    for (int c = 0; c < 10; c++) begin
      check("hold_state", {124'd0, in_ready, busy, cru, 1'b0}, 128'b0100);
      check("hold_s7", s_all[7], hold_exp[7]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    issue_en = 1'b1;
    #1;
    finish_issue("hold_release");

    // Flush together with an 8th valid operand discards the whole batch.
    for (int n = 0; n < 7; n++) send_op(32'h1234_5678, 1'b0);
    in_valid = 1'b1; in_data = 32'h9999_9999; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_clear", 128'(s_all != '0), 128'd0);
    check("flush_cnt", 128'(batch_cnt), 128'(exp_cnt));
    check("flush_pulses", 128'(pulses), 128'(exp_pulses));
    applyStimulus(vecs[0], 1'b0);

    // Flush during the firing issue cycle is ignored.
    applyStimulus('{"flush_in_issue", 3, 1'b0, 32'h3F80_0000, 1'b1,
                    spread(32'h3F80_0000, 3)}, 1'b1);

    // Asynchronous reset in the middle of a fill.
    for (int n = 0; n < 17; n++) send_op(32'h7777_7777, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_s", 128'(s_all != '0), 128'd0);
    check("midrst_flags", {125'd0, cru, busy, in_ready}, 128'b001);
    check("midrst_cnt", 128'(batch_cnt), 128'd0);
    exp_cnt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(vecs[1], 1'b0);

    @(posedge clk); #1;
    check("sb_empty", 128'(sb.size()), 128'd0);
    check("final_pulses", 128'(pulses), 128'(exp_pulses));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
